// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer
// Captures retire events from the core debug port into a small FIFO. Each entry
// carries a cycle stamp. Three capture policies are supported: stop when full,
// wrap (keep the newest entries), and PC trigger followed by a fixed number of
// post-trigger entries. The FIFO drains through a first-word-fall-through
// valid/ready port, and draining works in every state.

module pipeline_trace_buffer #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned POST_TRIG = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [1:0]                 mode,
   input  logic [XLEN-1:0]            trig_pc,
   input  logic                       clear,
   input  logic                       in_valid,
   input  logic [XLEN-1:0]            debug_pc,
   input  logic [XLEN-1:0]            debug_instr,
   input  logic                       debug_reg_we,
   input  logic [4:0]                 debug_reg_addr,
   input  logic [XLEN-1:0]            debug_reg_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CNT_W-1:0]           out_cycle,
   output logic [XLEN-1:0]            out_pc,
   output logic [XLEN-1:0]            out_instr,
   output logic [XLEN-1:0]            out_reg_data,
   output logic [4:0]                 out_reg_addr,
   output logic                       out_reg_we,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic [CNT_W-1:0]           overflow_cnt,
   output logic                       triggered
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned COUNT_W = PTR_W + 1;
   localparam int unsigned POST_W  = $clog2(POST_TRIG + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_ARMED,
      S_CAPTURE_POST,
      S_STOPPED
   } state_t;

   // The reserved encoding 2'b11 behaves exactly like STOP.
   typedef enum logic [1:0] {
      M_STOP = 2'b00,
      M_WRAP = 2'b01,
      M_TRIG = 2'b10
   } cap_mode_t;

   typedef struct packed {
      logic [CNT_W-1:0] cycle;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  instr;
      logic             reg_we;
      logic [4:0]       reg_addr;
      logic [XLEN-1:0]  reg_data;
   } entry_t;

   state_t            state, state_nxt;
   cap_mode_t         lmode, lmode_nxt;
   cap_mode_t         mode_in;
   logic [POST_W-1:0] post, post_nxt;

   logic [CNT_W-1:0]  cycle_cnt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              push_attempt;
   logic              trig_hit;
   logic              stop_lost;
   logic              pop;
   logic              blocked;
   logic              overwrite;
   logic              write_en;
   logic              rd_adv;
   logic              ovf_inc;

   entry_t            mem [DEPTH];
   entry_t            new_entry;
   entry_t            head;

   // Decode the mode input, folding the reserved value onto STOP.
   always_comb begin
      unique case (mode)
         2'b01:   mode_in = M_WRAP;
         2'b10:   mode_in = M_TRIG;
         default: mode_in = M_STOP;
      endcase
   end

   assign empty     = (count == '0);
   assign full      = (count == COUNT_W'(DEPTH));
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;

   // Next-state, push request and mode latch for the capture controller.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_nxt    = state;
      lmode_nxt    = lmode;
      post_nxt     = post;
      push_attempt = 1'b0;
      trig_hit     = 1'b0;
      stop_lost    = 1'b0;

      if (!enable) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               lmode_nxt = mode_in;
               state_nxt = (mode_in == M_TRIG) ? S_ARMED : S_CAPTURE;
            end
            S_CAPTURE: begin
               if (in_valid) begin
                  push_attempt = 1'b1;
                  // STOP freezes capture on the first event that finds no room.
                  if (full && !pop && lmode == M_STOP) state_nxt = S_STOPPED;
               end
            end
            S_ARMED: begin
               if (in_valid && debug_pc == trig_pc) begin
                  push_attempt = 1'b1;
                  trig_hit     = 1'b1;
                  post_nxt     = POST_W'(POST_TRIG - 1);
                  state_nxt    = (POST_TRIG == 1) ? S_STOPPED : S_CAPTURE_POST;
               end
            end
            S_CAPTURE_POST: begin
               if (in_valid) begin
                  push_attempt = 1'b1;
                  post_nxt     = post - POST_W'(1);
                  if (post == POST_W'(1)) state_nxt = S_STOPPED;
               end
            end
            S_STOPPED: begin
               // In STOP mode every retire seen after the freeze is a lost event.
               // A finished trigger window simply ignores later events.
               if (in_valid && lmode == M_STOP) stop_lost = 1'b1;
            end
            default: state_nxt = S_IDLE;
         endcase
      end

      if (clear) begin
         if (!enable) begin
            state_nxt = S_IDLE;
         end else begin
            if (state == S_IDLE) lmode_nxt = mode_in;
            state_nxt = (lmode_nxt == M_TRIG) ? S_ARMED : S_CAPTURE;
         end
      end
   end

   // FIFO control: decide whether the event is written, overwrites the oldest
   // entry, or is dropped. clear overrides every push and pop.
   always_comb begin
      blocked   = full && !pop;
      overwrite = push_attempt && blocked && state == S_CAPTURE && lmode == M_WRAP;
      write_en  = !clear && push_attempt && (!blocked || overwrite);
      rd_adv    = !clear && (pop || overwrite);
      ovf_inc   = !clear && ((push_attempt && blocked) || stop_lost);
   end

   // Build the entry from the debug port and the current cycle stamp.
   always_comb begin
      new_entry.cycle    = cycle_cnt;
      new_entry.pc       = debug_pc;
      new_entry.instr    = debug_instr;
      new_entry.reg_we   = debug_reg_we;
      new_entry.reg_addr = debug_reg_addr;
      new_entry.reg_data = debug_reg_data;
   end

   // Controller state, mode latch and post-trigger counter.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst_n) begin
         state <= S_IDLE;
         lmode <= M_STOP;
         post  <= '0;
      end else begin
         state <= state_nxt;
         lmode <= lmode_nxt;
         post  <= post_nxt;
      end
   end

   // Free-running cycle stamp, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cycle_cnt <= '0;
      else        cycle_cnt <= cycle_cnt + CNT_W'(1);
   end

   // Pointers and occupancy; pointer arithmetic wraps modulo DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (write_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_adv)   rd_ptr <= rd_ptr + PTR_W'(1);
         if (write_en && !rd_adv)      count <= count + COUNT_W'(1);
         else if (rd_adv && !write_en) count <= count - COUNT_W'(1);
      end
   end

   // Saturating lost-event counter and sticky trigger flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_cnt <= '0;
         triggered    <= 1'b0;
      end else if (clear) begin
         overflow_cnt <= '0;
         triggered    <= 1'b0;
      end else begin
         if (ovf_inc && overflow_cnt != '1) overflow_cnt <= overflow_cnt + CNT_W'(1);
         if (trig_hit) triggered <= 1'b1;
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; stale slots are never visible
      // because the head fields are forced to zero whenever the FIFO is empty.
      if (write_en) mem[wr_ptr] <= new_entry;
   end

   // Head slot presented combinationally, zero while empty.
   always_comb begin
      head = empty ? '0 : mem[rd_ptr];
   end

   assign out_cycle    = head.cycle;
   assign out_pc       = head.pc;
   assign out_instr    = head.instr;
   assign out_reg_we   = head.reg_we;
   assign out_reg_addr = head.reg_addr;
   assign out_reg_data = head.reg_data;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Self-checking bench for pipeline_trace_buffer: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based model of the capture rules.

module tb_pipeline_trace_buffer;

   localparam int DEPTH     = 16;
   localparam int POST_TRIG = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  mode;
   logic [31:0] trig_pc;
   logic        clear;
   logic        in_valid;
   logic [31:0] debug_pc;
   logic [31:0] debug_instr;
   logic        debug_reg_we;
   logic [4:0]  debug_reg_addr;
   logic [31:0] debug_reg_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_cycle;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_reg_data;
   logic [4:0]  out_reg_addr;
   logic        out_reg_we;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic [31:0] overflow_cnt;
   logic        triggered;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   pipeline_trace_buffer #(
      .XLEN(32), .DEPTH(DEPTH), .CNT_W(32), .POST_TRIG(POST_TRIG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .trig_pc(trig_pc),
      .clear(clear), .in_valid(in_valid), .debug_pc(debug_pc),
      .debug_instr(debug_instr), .debug_reg_we(debug_reg_we),
      .debug_reg_addr(debug_reg_addr), .debug_reg_data(debug_reg_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_cycle(out_cycle),
      .out_pc(out_pc), .out_instr(out_instr), .out_reg_data(out_reg_data),
      .out_reg_addr(out_reg_addr), .out_reg_we(out_reg_we), .count(count),
      .full(full), .empty(empty), .overflow_cnt(overflow_cnt), .triggered(triggered)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] cyc;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   localparam int ST_IDLE = 0, ST_RUN = 1, ST_ARMED = 2, ST_POST = 3, ST_STOPPED = 4;

   ent_t        q[$];
   int          m_st    = ST_IDLE;
   int          m_mode  = 0;
   int          m_post  = 0;
   logic [31:0] m_ovf   = '0;
   bit          m_trig  = 1'b0;
   logic [31:0] m_cyc   = '0;

   function automatic int eff_mode(input logic [1:0] m);
      return (m == 2'b11) ? 0 : int'(m);
   endfunction

   function automatic void bump();
      if (m_ovf != 32'hFFFF_FFFF) m_ovf++;
   endfunction

   // Store if there is room, otherwise count the event as lost.
   function automatic void store_or_drop(input ent_t e);
      if (q.size() < DEPTH) q.push_back(e);
      else bump();
   endfunction

   function automatic void model_step();
      ent_t e;
      bit   do_pop;
      int   nst;
      e.cyc = m_cyc; e.pc = debug_pc; e.instr = debug_instr;
      e.we = debug_reg_we; e.addr = debug_reg_addr; e.data = debug_reg_data;
      do_pop = (q.size() != 0) && out_ready;
      nst = m_st;
      if (clear) begin
         q.delete();
         m_ovf  = '0;
         m_trig = 1'b0;
         if (!enable) nst = ST_IDLE;
         else begin
            if (m_st == ST_IDLE) m_mode = eff_mode(mode);
            nst = (m_mode == 2) ? ST_ARMED : ST_RUN;
         end
      end else begin
         if (do_pop) void'(q.pop_front());
         if (!enable) nst = ST_IDLE;
         else case (m_st)
            ST_IDLE: begin
               m_mode = eff_mode(mode);
               nst = (m_mode == 2) ? ST_ARMED : ST_RUN;
            end
            ST_RUN: if (in_valid) begin
               if (q.size() < DEPTH) q.push_back(e);
               else if (m_mode == 1) begin
                  void'(q.pop_front());
                  q.push_back(e);
                  bump();
               end else begin
                  bump();
                  nst = ST_STOPPED;
               end
            end
            ST_ARMED: if (in_valid && debug_pc == trig_pc) begin
               m_trig = 1'b1;
               store_or_drop(e);
               m_post = POST_TRIG - 1;
               nst = (m_post == 0) ? ST_STOPPED : ST_POST;
            end
            ST_POST: if (in_valid) begin
               store_or_drop(e);
               m_post--;
               if (m_post == 0) nst = ST_STOPPED;
            end
            default: if (in_valid && m_mode == 0) bump();
         endcase
      end
      m_st  = nst;
      m_cyc = m_cyc + 32'd1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_st = ST_IDLE; m_mode = 0; m_post = 0;
         m_ovf = '0; m_trig = 1'b0; m_cyc = '0;
      end else begin
         model_step();
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         check("out_valid", out_valid, q.size() != 0);
         check("empty", empty, q.size() == 0);
         check("full", full, q.size() == DEPTH);
         check("count", count, q.size());
         check("overflow_cnt", overflow_cnt, m_ovf);
         check("triggered", triggered, m_trig);
         if (q.size() != 0) begin
            check("out_cycle", out_cycle, q[0].cyc);
            check("out_pc", out_pc, q[0].pc);
            check("out_instr", out_instr, q[0].instr);
            check("out_reg_we", out_reg_we, q[0].we);
            check("out_reg_addr", out_reg_addr, q[0].addr);
            check("out_reg_data", out_reg_data, q[0].data);
         end else begin
            check("out_pc_idle", out_pc, 0);
            check("out_cycle_idle", out_cycle, 0);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ev(input logic [31:0] pc);
      in_valid       = 1'b1;
      debug_pc       = pc;
      debug_instr    = $urandom;
      debug_reg_we   = 1'($urandom_range(0, 1));
      debug_reg_addr = 5'($urandom_range(0, 31));
      debug_reg_data = $urandom;
      tick();
   endtask

   // Return to IDLE with an empty buffer, then start capture in mode m.
   task automatic restart(input logic [1:0] m);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      enable    = 1'b0;
      clear     = 1'b1;
      tick();
      clear  = 1'b0;
      mode   = m;
      enable = 1'b1;
      tick();
   endtask

   // Drain n entries, expecting consecutive PCs from first and back-to-back stamps.
   task automatic drain(input logic [31:0] first, input int n, input string tag);
      logic [31:0] prev;
      prev = '0;
      out_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check({tag, "_pc"}, out_pc, first + 32'(4 * k));
         if (k > 0) check({tag, "_stamp"}, out_cycle, prev + 32'd1);
         prev = out_cycle;
         tick();
      end
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_empty"}, empty, 1'b1);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; mode = 2'b00; trig_pc = '0; clear = 1'b0;
      in_valid = 1'b0; debug_pc = '0; debug_instr = '0; debug_reg_we = 1'b0;
      debug_reg_addr = '0; debug_reg_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      cmp_en = 1'b1;

      // Reset state.
      @(negedge clk);
      check("rst_empty", empty, 1'b1);
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_ovf", overflow_cnt, 0);
      check("rst_pc", out_pc, 0);
      tick();

      // STOP: 20 events into 16 slots.
      restart(2'b00);
      for (int i = 0; i < 20; i++) ev(32'(4 * i));
      in_valid = 1'b0;
      @(negedge clk);
      check("stop_count", count, 16);
      check("stop_full", full, 1'b1);
      check("stop_ovf", overflow_cnt, 4);
      tick();
      drain(32'h0, 16, "stop_drain");

      // WRAP: newest 16 survive.
      restart(2'b01);
      for (int i = 0; i < 20; i++) ev(32'(4 * i));
      in_valid = 1'b0;
      @(negedge clk);
      check("wrap_ovf", overflow_cnt, 4);
      check("wrap_count", count, 16);
      tick();
      drain(32'h10, 16, "wrap_drain");

      // TRIG: window of 8 starting at 0x20.
      trig_pc = 32'h20;
      restart(2'b10);
      for (int i = 0; i < 32; i++) ev(32'(4 * i));
      in_valid = 1'b0;
      @(negedge clk);
      check("trig_flag", triggered, 1'b1);
      check("trig_count", count, 8);
      check("trig_ovf", overflow_cnt, 0);
      tick();
      drain(32'h20, 8, "trig_drain");

      // Full with simultaneous push and pop.
      restart(2'b00);
      for (int i = 0; i < 16; i++) ev(32'(4 * i));
      out_ready = 1'b1;
      for (int i = 16; i < 20; i++) ev(32'(4 * i));
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("pp_count", count, 16);
      check("pp_ovf", overflow_cnt, 0);
      tick();
      drain(32'h10, 16, "pp_drain");

      // Register-write fields, one cycle after capture.
      restart(2'b00);
      in_valid = 1'b1; debug_pc = 32'h100; debug_instr = 32'h0051_0293;
      debug_reg_we = 1'b1; debug_reg_addr = 5'd5; debug_reg_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("rw_not_yet", out_valid, 1'b0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("rw_we", out_reg_we, 1'b1);
      check("rw_addr", out_reg_addr, 5);
      check("rw_data", out_reg_data, 32'hDEAD_BEEF);
      check("rw_pc", out_pc, 32'h100);
      tick();

      // Asynchronous reset with 7 entries held.
      restart(2'b00);
      for (int i = 0; i < 7; i++) ev(32'(4 * i));
      in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_count", count, 7);
      #1 rst_n = 1'b0;
      #1;
      check("arst_empty", empty, 1'b1);
      check("arst_count", count, 0);
      check("arst_ovf", overflow_cnt, 0);
      check("arst_out_valid", out_valid, 1'b0);
      enable = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Randomized phase.
      begin
         int rdy_pct;
         rdy_pct = 40;
         enable = 1'b1;
         mode = 2'($urandom_range(0, 3));
         trig_pc = 32'(4 * $urandom_range(0, 15));
         for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) rdy_pct = $urandom_range(5, 90);
            if ($urandom_range(0, 99) < 3) begin
               enable = ~enable;
               mode = 2'($urandom_range(0, 3));
               trig_pc = 32'(4 * $urandom_range(0, 15));
            end
            clear          = ($urandom_range(0, 99) < 2);
            in_valid       = ($urandom_range(0, 99) < 60);
            out_ready      = ($urandom_range(0, 99) < rdy_pct);
            debug_pc       = 32'(4 * $urandom_range(0, 15));
            debug_instr    = $urandom;
            debug_reg_we   = 1'($urandom_range(0, 1));
            debug_reg_addr = 5'($urandom_range(0, 31));
            debug_reg_data = $urandom;
            tick();
         end
         clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
